// File: rtl/result_demux.sv
// result_demux: routes datapath result words to a register-path port (A) or an address-path port (B)
// Each port has a one-word holding slot that can drain and reload in the same cycle.
// Ports:
//   clk, rst_n (async, active low)
//   in_data[18:0], in_sel (1=A, 0=B), in_valid, in_ready
//   outA_data[18:0], outA_valid, outA_ready
//   outB_data[13:0], outB_ovf (upper five bits were non-zero), outB_valid, outB_ready
//   ovf_cnt[7:0]: saturating count of overflowed port-B transfers
// Optional feature macro: RESULT_DEMUX_OVF_CNT_EN enables ovf_cnt (otherwise tied to 0).
module result_demux (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [18:0] in_data,
  input  logic        in_sel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [18:0] outA_data,
  output logic        outA_valid,
  input  logic        outA_ready,
  output logic [13:0] outB_data,
  output logic        outB_ovf,
  output logic        outB_valid,
  input  logic        outB_ready,
  output logic [7:0]  ovf_cnt
);
  logic a_free, b_free, load_a, load_b;
  assign a_free   = !outA_valid || outA_ready;
  assign b_free   = !outB_valid || outB_ready;
  assign in_ready = in_sel ? a_free : b_free;
  assign load_a   = in_valid && in_sel && a_free;
  assign load_b   = in_valid && !in_sel && b_free;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outA_data  <= '0;
      outA_valid <= 1'b0;
      outB_data  <= '0;
      outB_ovf   <= 1'b0;
      outB_valid <= 1'b0;
    end else begin
      if (load_a) begin
        outA_data  <= in_data;
        outA_valid <= 1'b1;
      end else if (outA_ready) begin
        outA_valid <= 1'b0;
      end
      if (load_b) begin
        outB_data  <= in_data[13:0];
        outB_ovf   <= |in_data[18:14];
        outB_valid <= 1'b1;
      end else if (outB_ready) begin
        outB_valid <= 1'b0;
      end
    end
  end
`ifdef RESULT_DEMUX_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_cnt <= '0;
    else if (outB_valid && outB_ready && outB_ovf && ovf_cnt != 8'hff) ovf_cnt <= ovf_cnt + 8'd1;
  end
`else
  assign ovf_cnt = '0;
`endif
endmodule

// File: tb/tb_result_demux.sv
// tb_result_demux: directed and scoreboard checks for result_demux
module tb_result_demux;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [18:0] outA_data;
  logic        outA_valid;
  logic        outA_ready = 1'b0;
  logic [13:0] outB_data;
  logic        outB_ovf;
  logic        outB_valid;
  logic        outB_ready = 1'b0;
  logic [7:0]  ovf_cnt;
  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [18:0] qa[$];
  logic [14:0] qb[$];
  result_demux dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .outA_data(outA_data), .outA_valid(outA_valid), .outA_ready(outA_ready),
    .outB_data(outB_data), .outB_ovf(outB_ovf), .outB_valid(outB_valid), .outB_ready(outB_ready),
    .ovf_cnt(ovf_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic mon();
    logic [18:0] ea;
    logic [14:0] eb;
    if (in_valid && in_ready) begin
      if (in_sel) qa.push_back(in_data);
      else qb.push_back({|in_data[18:14], in_data[13:0]});
    end
    if (outA_valid && outA_ready) begin
      if (qa.size() == 0) check("sb_a_unexpected", 32'd1, 32'd0);
      else begin
        ea = qa.pop_front();
        check("sb_a_data", outA_data, ea);
      end
    end
    if (outB_valid && outB_ready) begin
      if (qb.size() == 0) check("sb_b_unexpected", 32'd1, 32'd0);
      else begin
        eb = qb.pop_front();
        check("sb_b_word", {outB_ovf, outB_data}, eb);
`ifdef RESULT_DEMUX_OVF_CNT_EN
        if (eb[14] && exp_cnt < 255) exp_cnt++;
`endif
      end
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic sel, input logic [18:0] d);
    in_sel = sel;
    in_data = d;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask
  initial begin
    #1;
    check("rst_a_valid", outA_valid, 0);
    check("rst_b_valid", outB_valid, 0);
    check("rst_a_data", outA_data, 0);
    check("rst_b_data", {outB_ovf, outB_data}, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    in_sel = 1'b1;
    #1 check("post_rst_ready_a", in_ready, 1);
    in_sel = 1'b0;
    #1 check("post_rst_ready_b", in_ready, 1);
    outA_ready = 1'b1;
    outB_ready = 1'b1;
    send(1'b1, 19'h5_A5A5);
    check("a_first_valid", outA_valid, 1);
    check("a_first_data", outA_data, 19'h5_A5A5);
    check("a_first_b_idle", outB_valid, 0);
    cyc();
    send(1'b0, 19'h7_C123);
    check("b_ovf_valid", outB_valid, 1);
    check("b_ovf_data", outB_data, 14'h0123);
    check("b_ovf_flag", outB_ovf, 1);
    send(1'b0, 19'h0_1FFF);
    check("b_noovf_data", outB_data, 14'h1FFF);
    check("b_noovf_flag", outB_ovf, 0);
    cyc();
    outA_ready = 1'b0;
    send(1'b1, 19'h1_1111);
    in_sel = 1'b1;
    in_data = 19'h2_2222;
    in_valid = 1'b1;
    #1 check("a_full_ready", in_ready, 0);
    cyc();
    check("a_held_data", outA_data, 19'h1_1111);
    check("a_held_valid", outA_valid, 1);
    in_sel = 1'b0;
    in_data = 19'h0_3333;
    #1 check("b_free_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    check("b_accepted", {outB_valid, outB_data}, {1'b1, 14'h3333});
    check("a_still_held", outA_data, 19'h1_1111);
    outA_ready = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 19'(19'h4_0000 + i * 19'h111));
      check("a_b2b_valid", outA_valid, 1);
      check("a_b2b_data", outA_data, 19'(19'h4_0000 + i * 19'h111));
      in_valid = 1'b0;
    end
    cyc();
    check("a_b2b_drained", outA_valid, 0);
    for (int i = 0; i < 60; i++) begin
      in_sel = 1'($urandom_range(0, 1));
      in_data = 19'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      outA_ready = 1'($urandom_range(0, 1));
      outB_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    in_valid = 1'b0;
    outA_ready = 1'b1;
    outB_ready = 1'b1;
    cyc();
    cyc();
    check("rand_qa_empty", qa.size(), 0);
    check("rand_qb_empty", qb.size(), 0);
    outA_ready = 1'b0;
    outB_ready = 1'b0;
    send(1'b1, 19'h6_0001);
    send(1'b0, 19'h6_0002);
    check("pre_rst_both_valid", {outA_valid, outB_valid}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("async_rst_valids", {outA_valid, outB_valid}, 2'b00);
    check("async_rst_data", {outA_data, outB_ovf, outB_data}, 0);
    check("async_rst_cnt", ovf_cnt, 0);
    qa.delete();
    qb.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    outA_ready = 1'b1;
    outB_ready = 1'b1;
    check("rst2_no_a_out", outA_valid, 0);
    in_sel = 1'b1;
    #1 check("rst2_ready_a", in_ready, 1);
    in_sel = 1'b0;
    #1 check("rst2_ready_b", in_ready, 1);
    for (int i = 0; i < 260; i++) begin
      in_sel = 1'b0;
      in_data = 19'(19'h4_0000 + i);
      in_valid = 1'b1;
      cyc();
      if (i == 9) check("ovf_cnt_mid", ovf_cnt, exp_cnt);
    end
    in_valid = 1'b0;
    cyc();
    cyc();
`ifdef RESULT_DEMUX_OVF_CNT_EN
    check("ovf_cnt_sat", ovf_cnt, 255);
`else
    check("ovf_cnt_off", ovf_cnt, 0);
`endif
    check("ovf_cnt_model", ovf_cnt, exp_cnt);
    check("final_qb_empty", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/result_demux.md
RESULT_DEMUX -- requirements
Module: result_demux

Interface
- REQ-001: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-002: rst_n  input  1  asynchronous, active-low reset.
- REQ-003: in_data  input  19  result word from the datapath.
- REQ-004: in_sel  input  1  destination select: 1 = port A, 0 = port B.
- REQ-005: in_valid  input  1  in_data/in_sel qualified.
- REQ-006: in_ready  output  1  the selected destination can accept this cycle.
- REQ-007: outA_data  output  19  full-width result to the register path.
- REQ-008: outA_valid  output  1  outA_data qualified.
- REQ-009: outA_ready  input  1  port A sink accepts.
- REQ-010: outB_data  output  14  low 14 bits of the result, to the address path.
- REQ-011: outB_ovf  output  1  in_data[18:14] was non-zero for the word in outB_data.
- REQ-012: outB_valid  output  1  outB_data/outB_ovf qualified.
- REQ-013: outB_ready  input  1  port B sink accepts.
- REQ-014: ovf_cnt  output  8  count of overflowed port-B transfers (see Configuration).

Function
- REQ-015: Each port SHALL have one holding slot: data register plus valid flag.
- REQ-016: A slot is free when its valid flag is 0, or when valid and ready are both 1 this cycle.
- REQ-017: in_ready SHALL be the free status of the slot selected by in_sel, computed combinationally.
- REQ-018: in_ready SHALL NOT depend on in_valid.
- REQ-019: Transfer in: in_valid and in_ready both 1 at a clock edge load the selected slot; its valid flag is 1 after that edge.
- REQ-020: Latency from input transfer to output valid SHALL be exactly 1 cycle.
- REQ-021: Port A load: outA_data = in_data.
- REQ-022: Port B load: outB_data = in_data[13:0] and outB_ovf = |in_data[18:14], both in the same edge.
- REQ-023: Transfer out: the slot's valid flag clears at an edge where valid and ready are both 1, unless it is reloaded at that same edge.
- REQ-024: Simultaneous drain and load on one port: new data replaces old and valid stays 1; no bubble, no loss.
- REQ-025: Output data SHALL hold stable while valid=1 and ready=0.
- REQ-026: The unselected port is unaffected by input traffic.
- REQ-027: No ordering is guaranteed between ports A and B.
- REQ-028: Order within each port is preserved.
- REQ-029: in_valid=0 SHALL leave both slots unchanged apart from drains.

Reset
- REQ-030: rst_n low SHALL immediately force all valid flags, output data, outB_ovf and ovf_cnt to 0.
- REQ-031: Reset mid-transfer SHALL discard held words, with no output transfer at that edge.
- REQ-032: After rst_n deasserts, in_ready SHALL read 1 for both in_sel values.

Configuration
- REQ-033: Macro RESULT_DEMUX_OVF_CNT_EN defined: ovf_cnt increments by 1 on each port-B output transfer where outB_ovf=1.
- REQ-034: ovf_cnt saturates at 255 and never wraps.
- REQ-035: Macro RESULT_DEMUX_OVF_CNT_EN undefined: ovf_cnt is tied to 0 and no counter logic exists.

Verification
- REQ-036: After reset, in_sel=1, in_data=19'h5_A5A5, in_valid=1, outA_ready=1 -> outA_valid=1 with 19'h5_A5A5 the next cycle; outB_valid stays 0.
- REQ-037: in_sel=0, in_data=19'h7_C123 -> outB_data=14'h0123, outB_ovf=1.
- REQ-038: in_sel=0, in_data=19'h0_1FFF -> outB_ovf=0.
- REQ-039: Port A held with outA_ready=0, second A word offered -> in_ready=0 and outA_data unchanged; with in_sel=0 on the same cycle, in_ready=1 and the B word is accepted.
- REQ-040: Back-to-back A words with outA_ready=1 every cycle -> one word per cycle, in order, no gaps.
- REQ-041: rst_n pulsed low while both slots are valid -> both valid flags go 0 asynchronously, before the next clock edge.
- REQ-042: With RESULT_DEMUX_OVF_CNT_EN defined, 260 overflowed B transfers -> ovf_cnt=255.
- REQ-043: With RESULT_DEMUX_OVF_CNT_EN undefined, the same stimulus -> ovf_cnt=0.
